control_movimiento: RTL and testbench
=====================================

// Module: control_movimiento
// PURPOSE
// Elevator motion/scheduling stage, directly upstream of the door controller.
// - Latches floor calls and tracks the cabin floor from the one-hot floor sensors.
// - Drives the motor using collective (same-direction-first) scheduling.
// - Publishes estado[3:0] to the door controller.
// - Holds the cabin stopped while the door controller reports trabajando.
// PARAMETERS
// N_PISOS       10    number of floors; width of pisos/botones/pendientes
// FRENO_CICLOS  4     cycles motor is held stopped in FRENANDO before EN_PISO
// ESPERA_MAX    1024  cycles to wait for trabajando to rise before giving up
// PORTS
// clk          in   1        system clock
// rst_n        in   1        synchronous reset, active-low
// pisos        in   N_PISOS  floor sensors; one-hot at a floor, all-zero between floors
// botones      in   N_PISOS  call buttons; level or pulse, OR-latched
// trabajando   in   1        door controller busy (door cycle in progress)
// estado       out  4        current FSM state code (ascensor_pkg::estado_t)
// motor        out  2        00 stop, 01 up, 10 down (11 never driven)
// pendientes   out  N_PISOS  latched, unserved calls
// piso_actual  out  4        last valid floor index, $clog2(N_PISOS) bits
// dir_arriba   out  1        current/last travel direction, 1 = up
// BEHAVIOUR
// - One clock (clk). Reset is synchronous, active-low (rst_n sampled on posedge clk).
// - Reset values: estado=REPOSO, motor=00, pendientes=0, piso_actual=0, dir_arriba=1.
// - Reset mid-travel drops every call and stops the motor the next edge.
// - Calls: pendientes <= (pendientes | botones) & ~servido.
//   - servido is one-hot of piso_actual, only in EN_PISO.
//   - A call on the served floor in that same cycle is consumed.
// - Floor tracking:
//   - pisos one-hot: piso_actual <= index, registered.
//   - pisos all-zero: hold.
//   - More than one bit set: -> ERROR.
// - Scheduler (combinational sub-module) derives hay_arriba, hay_abajo, aqui
//   from pendientes and piso_actual.
// - FSM states (codes in package):
//   REPOSO=0, SUBIENDO=1, BAJANDO=2, FRENANDO=3, EN_PISO=4, ESPERA_PUERTAS=5, ERROR=15.
//   - REPOSO: motor=00.
//     - aqui -> EN_PISO.
//     - else if dir_arriba: hay_arriba -> SUBIENDO, else hay_abajo -> BAJANDO.
//     - else (dir down): hay_abajo -> BAJANDO, else hay_arriba -> SUBIENDO.
//     - SUBIENDO sets dir_arriba=1; BAJANDO sets dir_arriba=0.
//   - SUBIENDO/BAJANDO: motor=01/10.
//     - On a cycle where pisos is one-hot at floor f with pendientes[f] set -> FRENANDO.
//     - Safety: pisos[N_PISOS-1] while up, or pisos[0] while down, with no call there -> ERROR.
//   - FRENANDO: motor=00, counter 0..FRENO_CICLOS-1, then -> EN_PISO.
//   - EN_PISO: one cycle; signals door open request; clears call; -> ESPERA_PUERTAS.
//   - ESPERA_PUERTAS: motor=00.
//     - Waits for trabajando high, then trabajando low -> REPOSO.
//     - If trabajando never rises within ESPERA_MAX cycles -> REPOSO.
//   - ERROR: motor=00; sticky until rst_n=0; calls still latched.
// - motor is a registered output, decoded from next state: changes on the same edge as estado.
// - Wait counter width: $clog2(ESPERA_MAX+1).
// - Counters clear on every state entry.
// STRUCTURE
// - ascensor_pkg: estado_t enum (4-bit codes above), motor codes
//   MOTOR_PARO/SUBE/BAJA, N_PISOS_DEF, function onehot_a_indice().
// - Sub-module selector_direccion: combinational; in pendientes, piso_actual;
//   out hay_arriba, hay_abajo, aqui.
// - Top module: FSM, call register, floor register, counters.
// TESTING
// 1. rst_n=0 for 2 cycles mid-SUBIENDO, pendientes=0x3F0
//    -> next edge: estado=0, motor=00, pendientes=0.
// 2. Idle at floor 0, botones[3] pulse
//    -> SUBIENDO; pisos=0x008 -> FRENANDO 4 cycles -> EN_PISO (pendientes[3]=0)
//    -> ESPERA_PUERTAS; trabajando 1 then 0 -> REPOSO.
// 3. At floor 5, dir up, calls 2 and 8 -> goes up first, serves 8, then down to 2.
// 4. Call on current floor while REPOSO
//    -> EN_PISO next cycle, motor never leaves 00.
// 5. pisos=0x011 while moving -> ERROR, motor=00;
//    stays in ERROR despite new calls until rst_n=0.
// 6. EN_PISO with trabajando held 0
//    -> ESPERA_PUERTAS exits to REPOSO after exactly ESPERA_MAX cycles.

Source files
------------

// File: rtl/ascensor_pkg.sv
// Shared types and helpers for the elevator motion controller.
// State codes are visible to the door controller, so they are fixed here.
package ascensor_pkg;

  localparam int N_PISOS_DEF = 10;

  typedef enum logic [3:0] {
    REPOSO         = 4'd0,
    SUBIENDO       = 4'd1,
    BAJANDO        = 4'd2,
    FRENANDO       = 4'd3,
    EN_PISO        = 4'd4,
    ESPERA_PUERTAS = 4'd5,
    ERROR          = 4'd15
  } estado_t;

  localparam logic [1:0] MOTOR_PARO = 2'b00;
  localparam logic [1:0] MOTOR_SUBE = 2'b01;
  localparam logic [1:0] MOTOR_BAJA = 2'b10;

  // OR of the indices of all set bits; equals the bit index when v is one-hot.
  function automatic int onehot_a_indice(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

  function automatic logic [1:0] motor_de(input estado_t e);
    case (e)
      SUBIENDO: return MOTOR_SUBE;
      BAJANDO:  return MOTOR_BAJA;
      default:  return MOTOR_PARO;
    endcase
  endfunction

endpackage

// File: rtl/control_movimiento_selector_direccion.sv
// Combinational call scan: pending calls above, below and at the cabin floor.
module selector_direccion #(
  parameter int N_PISOS = 10,
  parameter int PW      = 4
) (
  input  logic [N_PISOS-1:0] pendientes,
  input  logic [PW-1:0]      piso_actual,
  output logic               hay_arriba,
  output logic               hay_abajo,
  output logic               aqui
);

  always_comb begin
    hay_arriba = 1'b0;
    hay_abajo  = 1'b0;
    aqui       = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (pendientes[i]) begin
        if (PW'(i) > piso_actual) hay_arriba = 1'b1;
        if (PW'(i) < piso_actual) hay_abajo  = 1'b1;
        if (PW'(i) == piso_actual) aqui      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_movimiento.sv
// Elevator motion FSM: call latching, floor tracking and collective scheduling.
// state          | meaning
// REPOSO         | stopped, choosing the next direction
// SUBIENDO       | motor up, looking for a called floor
// BAJANDO        | motor down, looking for a called floor
// FRENANDO       | motor held stopped for FRENO_CICLOS cycles
// EN_PISO        | one cycle at the floor: door request, call cleared
// ESPERA_PUERTAS | waiting for the door controller cycle (or timeout)
// ERROR          | sensor fault, sticky until reset
module control_movimiento
  import ascensor_pkg::*;
#(
  parameter int N_PISOS      = N_PISOS_DEF,
  parameter int FRENO_CICLOS = 4,
  parameter int ESPERA_MAX   = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PISOS-1:0]         pisos,
  input  logic [N_PISOS-1:0]         botones,
  input  logic                       trabajando,
  output logic [3:0]                 estado,
  output logic [1:0]                 motor,
  output logic [N_PISOS-1:0]         pendientes,
  output logic [$clog2(N_PISOS)-1:0] piso_actual,
  output logic                       dir_arriba
);

  localparam int PW = $clog2(N_PISOS);
  localparam int CW = $clog2(ESPERA_MAX + 1);

  estado_t            st, sig;
  logic [CW-1:0]      cnt;
  logic               visto;
  logic               dir_sig;
  logic               hay_arriba, hay_abajo, aqui;
  logic               pisos_varios, pisos_uno, llamada_sensor;
  logic [PW-1:0]      idx;
  logic [N_PISOS-1:0] servido;

  assign estado = st;

  selector_direccion #(.N_PISOS(N_PISOS), .PW(PW)) u_selector (
    .pendientes  (pendientes),
    .piso_actual (piso_actual),
    .hay_arriba  (hay_arriba),
    .hay_abajo   (hay_abajo),
    .aqui        (aqui)
  );

  always_comb begin
    pisos_varios   = (pisos & (pisos - N_PISOS'(1))) != '0;
    pisos_uno      = (pisos != '0) && !pisos_varios;
    idx            = PW'(onehot_a_indice(32'(pisos)));
    llamada_sensor = pisos_uno && pendientes[idx];
    servido        = (st == EN_PISO) ? (N_PISOS'(1) << piso_actual) : '0;
    sig            = st;
    dir_sig        = dir_arriba;
    case (st)
      REPOSO: begin
        if (aqui) sig = EN_PISO;
        else if (dir_arriba) begin
          if (hay_arriba) sig = SUBIENDO;
          else if (hay_abajo) sig = BAJANDO;
        end else begin
          if (hay_abajo) sig = BAJANDO;
          else if (hay_arriba) sig = SUBIENDO;
        end
      end
      SUBIENDO: begin
        if (llamada_sensor) sig = FRENANDO;
        else if (pisos[N_PISOS-1]) sig = ERROR;
      end
      BAJANDO: begin
        if (llamada_sensor) sig = FRENANDO;
        else if (pisos[0]) sig = ERROR;
      end
      FRENANDO:
        if (cnt == CW'(FRENO_CICLOS - 1)) sig = EN_PISO;
      EN_PISO:
        sig = ESPERA_PUERTAS;
      ESPERA_PUERTAS: begin
        // A door cycle that starts on the last wait cycle still counts as seen.
        if (!trabajando && (visto || cnt == CW'(ESPERA_MAX - 1))) sig = REPOSO;
      end
      ERROR:   sig = ERROR;
      default: sig = ERROR;
    endcase
    if (pisos_varios) sig = ERROR;
    if (sig == SUBIENDO) dir_sig = 1'b1;
    if (sig == BAJANDO)  dir_sig = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= REPOSO;
      motor       <= MOTOR_PARO;
      pendientes  <= '0;
      piso_actual <= '0;
      dir_arriba  <= 1'b1;
      cnt         <= '0;
      visto       <= 1'b0;
    end else begin
      st         <= sig;
      motor      <= motor_de(sig);
      pendientes <= (pendientes | botones) & ~servido;
      dir_arriba <= dir_sig;
      if (pisos_uno) piso_actual <= idx;
      if (sig != st) begin
        cnt   <= '0;
        visto <= 1'b0;
      end else begin
        if (cnt != '1) cnt <= cnt + CW'(1);
        if (st == ESPERA_PUERTAS && trabajando) visto <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_movimiento.sv
// Bench for control_movimiento: simulated shaft and door controller, trip-level
// reference model of collective scheduling, directed and random call batches.
module tb_control_movimiento;
  import ascensor_pkg::*;

  localparam int N      = 10;
  localparam int FRENO  = 4;
  localparam int ESPERA = 1024;
  localparam int S      = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pisos, botones;
  logic       trabajando;
  logic [3:0] estado;
  logic [1:0] motor;
  logic [9:0] pendientes;
  logic [3:0] piso_actual;
  logic       dir_arriba;

  always #5 clk = ~clk;

  control_movimiento #(.N_PISOS(N), .FRENO_CICLOS(FRENO), .ESPERA_MAX(ESPERA)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pisos       (pisos),
    .botones     (botones),
    .trabajando  (trabajando),
    .estado      (estado),
    .motor       (motor),
    .pendientes  (pendientes),
    .piso_actual (piso_actual),
    .dir_arriba  (dir_arriba)
  );

  int n_total = 0;
  int n_pass  = 0;
  int pos = 0;
  bit forzar = 0;
  logic [9:0] pisos_forzado = '0;
  bit auto_puertas = 1;
  bit door_started = 0;
  int door_delay = 0, door_len = 0;
  int m_floor = 0;
  bit m_dir = 1;
  bit m_dir_fin;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: sample after the edge, then move the cabin and run the doors.
  task automatic tick();
    @(posedge clk);
    #1;
    if (motor == 2'b01) pos++;
    else if (motor == 2'b10) pos--;
    if (pos < 0) pos = 0;
    if (pos > (N - 1) * S) pos = (N - 1) * S;
    pisos = forzar ? pisos_forzado : ((pos % S == 0) ? (10'd1 << (pos / S)) : 10'd0);
    if (auto_puertas) begin
      if (estado == ESPERA_PUERTAS) begin
        if (!door_started) begin
          door_started = 1;
          door_delay   = $urandom_range(0, 4);
          door_len     = $urandom_range(1, 5);
        end
        if (door_delay > 0) begin
          door_delay--;
          trabajando = 1'b0;
        end else if (door_len > 0) begin
          door_len--;
          trabajando = 1'b1;
        end else trabajando = 1'b0;
      end else begin
        door_started = 0;
        trabajando   = 1'b0;
      end
    end
  endtask

  function automatic int arriba(input logic [9:0] c, input int f);
    for (int i = f + 1; i < N; i++) if (c[i]) return i;
    return -1;
  endfunction

  function automatic int abajo(input logic [9:0] c, input int f);
    for (int i = f - 1; i >= 0; i--) if (c[i]) return i;
    return -1;
  endfunction

  // Expected visiting order: current floor first, then nearest in the travel
  // direction, reversing only when nothing remains ahead.
  task automatic model_plan(input logic [9:0] calls);
    logic [9:0] c;
    int f, t;
    bit d;
    c = calls; f = m_floor; d = m_dir;
    exp_q.delete();
    while (c != 0) begin
      if (c[f]) t = f;
      else if (d) begin
        t = arriba(c, f);
        if (t < 0) t = abajo(c, f);
      end else begin
        t = abajo(c, f);
        if (t < 0) t = arriba(c, f);
      end
      if (t > f) d = 1;
      else if (t < f) d = 0;
      exp_q.push_back(t);
      c[t] = 1'b0;
      f = t;
    end
    m_dir_fin = d;
  endtask

  task automatic wait_estado(input logic [3:0] e, input string tag, input int budget);
    int g;
    g = 0;
    while (estado !== e && g < budget) begin
      tick();
      g++;
    end
    if (estado !== e) chk({tag, "_timeout"}, 32'(estado), 32'(e));
  endtask

  task automatic serve_batch(input logic [9:0] calls, input string tag);
    logic [9:0] rem;
    int guard, fcnt, mfloor, t;
    bit moved, chk_pend;
    model_plan(calls);
    rem = calls; guard = 0; fcnt = 0; moved = 0; chk_pend = 0; mfloor = m_floor;
    botones = calls;
    tick();
    botones = '0;
    while (1) begin
      if (guard >= 3000) begin
        chk({tag, "_timeout_legs_left"}, 32'(exp_q.size()), 32'd0);
        break;
      end
      tick();
      guard++;
      if (chk_pend) begin
        chk({tag, "_pendientes"}, 32'(pendientes), 32'(rem));
        chk_pend = 0;
      end
      if (estado == FRENANDO) fcnt++;
      if (motor != 2'b00) moved = 1;
      if (estado == EN_PISO) begin
        t = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk({tag, "_piso"}, 32'(piso_actual), 32'(t));
        chk({tag, "_freno"}, 32'(fcnt), (t == mfloor) ? 32'd0 : 32'(FRENO));
        chk({tag, "_movio"}, 32'(moved), 32'(t != mfloor));
        if (t >= 0) rem[t] = 1'b0;
        mfloor = t; fcnt = 0; moved = 0; chk_pend = 1;
      end
      if (exp_q.size() == 0 && !chk_pend && estado == REPOSO) break;
    end
    chk({tag, "_dir"}, 32'(dir_arriba), 32'(m_dir_fin));
    m_floor = mfloor;
    m_dir   = m_dir_fin;
  endtask

  initial begin
    int n, objetivo;
    logic [9:0] c;
    rst_n = 1'b0; botones = '0; trabajando = 1'b0; pisos = 10'h001;
    tick();
    tick();
    chk("rst_estado", 32'(estado), 32'(REPOSO));
    chk("rst_motor", 32'(motor), 32'd0);
    chk("rst_pendientes", 32'(pendientes), 32'd0);
    chk("rst_piso", 32'(piso_actual), 32'd0);
    chk("rst_dir", 32'(dir_arriba), 32'd1);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of an upward trip.
    botones = 10'h3F0;
    tick();
    botones = '0;
    wait_estado(SUBIENDO, "t1_sube", 10);
    tick();
    chk("t1_pend_antes", 32'(pendientes), 32'h3F0);
    chk("t1_motor_sube", 32'(motor), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t1_estado", 32'(estado), 32'(REPOSO));
    chk("t1_motor", 32'(motor), 32'd0);
    chk("t1_pendientes", 32'(pendientes), 32'd0);
    tick();
    rst_n = 1'b1;
    pos = 0; pisos = 10'h001; m_floor = 0; m_dir = 1;
    tick();

    serve_batch(10'h008, "t2");
    serve_batch(10'h020, "t3a");
    serve_batch(10'h104, "t3b");

    // Call on the cabin floor while idle.
    botones = 10'(1 << m_floor);
    tick();
    botones = '0;
    tick();
    chk("t4_en_piso", 32'(estado), 32'(EN_PISO));
    chk("t4_motor", 32'(motor), 32'd0);
    wait_estado(REPOSO, "t4_reposo", 100);
    chk("t4_pendientes", 32'(pendientes), 32'd0);

    for (int k = 0; k < 6; k++) serve_batch(10'($urandom_range(1, 1023)), "rnd");

    // Door controller never answers.
    auto_puertas = 0;
    trabajando   = 1'b0;
    botones = 10'(1 << m_floor);
    tick();
    botones = '0;
    wait_estado(ESPERA_PUERTAS, "t6_espera", 10);
    n = 0;
    while (estado == ESPERA_PUERTAS && n < 2000) begin
      tick();
      n++;
    end
    chk("t6_ciclos_espera", 32'(n), 32'(ESPERA));
    chk("t6_estado", 32'(estado), 32'(REPOSO));
    auto_puertas = 1;
    tick();

    // Two floor sensors at once while travelling.
    objetivo = (m_floor < 5) ? 9 : 0;
    botones = 10'(1 << objetivo);
    tick();
    botones = '0;
    n = 0;
    while (!(estado == SUBIENDO || estado == BAJANDO) && n < 20) begin
      tick();
      n++;
    end
    chk("t5_en_marcha", 32'(motor != 2'b00), 32'd1);
    forzar = 1; pisos_forzado = 10'h011; pisos = 10'h011;
    tick();
    chk("t5_error", 32'(estado), 32'(ERROR));
    chk("t5_motor", 32'(motor), 32'd0);
    c = 10'($urandom_range(1, 1023));
    botones = c;
    tick();
    botones = '0;
    for (int k = 0; k < 5; k++) tick();
    chk("t5_pegado", 32'(estado), 32'(ERROR));
    chk("t5_llamadas", 32'(pendientes & c), 32'(c));
    chk("t5_motor_pegado", 32'(motor), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_estado", 32'(estado), 32'(REPOSO));
    chk("t5_rst_pend", 32'(pendientes), 32'd0);
    rst_n = 1'b1; forzar = 0; pos = 0; pisos = 10'h001;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
